// File: rtl/matmult_result_serializer_if.sv
// Handshake bundle between the matmult result stage, the serializer and the downstream consumer.
// Checksum ports exist only when SERIALIZER_CHECKSUM_EN is defined.
interface matmult_result_serializer_if #(
  parameter int DATA_W = 64,
  parameter int N_ELEM = 25
);
  logic                     in_valid;
  logic                     in_accept;
  logic signed [DATA_W-1:0] in_c [N_ELEM];
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [4:0]               out_index;
  logic                     out_last;
`ifdef SERIALIZER_CHECKSUM_EN
  logic signed [DATA_W-1:0] out_sum;
  logic                     out_sum_valid;

  modport master (
    output in_valid, in_c, out_ready,
    input  in_accept, out_valid, out_data, out_index, out_last, out_sum, out_sum_valid
  );
  modport slave (
    input  in_valid, in_c, out_ready,
    output in_accept, out_valid, out_data, out_index, out_last, out_sum, out_sum_valid
  );
`else
  modport master (
    output in_valid, in_c, out_ready,
    input  in_accept, out_valid, out_data, out_index, out_last
  );
  modport slave (
    input  in_valid, in_c, out_ready,
    output in_accept, out_valid, out_data, out_index, out_last
  );
`endif
endinterface

// File: rtl/matmult_result_serializer.sv
// Captures a 5x5 result matrix and streams it out one element per accepted beat, row-major.
// Optional running checksum of transferred elements when SERIALIZER_CHECKSUM_EN is defined.
module matmult_result_serializer #(
  parameter int DATA_W = 64,
  parameter int N_ELEM = 25
) (
  input  logic                          clk,
  input  logic                          rst,
  matmult_result_serializer_if.slave    bus
);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACK  = 2'b01,
    SEND = 2'b10
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(N_ELEM - 1);

  state_t                   state_q, state_d;
  logic [4:0]               index_q, index_d;
  logic signed [DATA_W-1:0] buf_q [N_ELEM];
  logic                     capture;
  logic                     accept;
  logic                     send;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    capture = 1'b0;
    accept  = 1'b0;
    send    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          capture = 1'b1;
          state_d = ACK;
        end
      end
      // in_valid is deliberately not looked at here or in SEND
      ACK: begin
        accept  = 1'b1;
        state_d = SEND;
        index_d = '0;
      end
      SEND: begin
        send = 1'b1;
        if (bus.out_ready) begin
          if (index_q == LAST_IDX) begin
            state_d = IDLE;
            index_d = '0;
          end else begin
            index_d = index_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        index_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ELEM; i++) buf_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < N_ELEM; i++) buf_q[i] <= bus.in_c[i];
    end
  end

  // Outputs decode only from state/index/buffer flops; out_ready never reaches them.
  assign bus.in_accept = accept;
  assign bus.out_valid = send;
  assign bus.out_data  = send ? buf_q[index_q] : '0;
  assign bus.out_index = send ? index_q : 5'd0;
  assign bus.out_last  = send && (index_q == LAST_IDX);

`ifdef SERIALIZER_CHECKSUM_EN
  logic                     xfer;
  logic signed [DATA_W-1:0] sum_q;
  logic                     sum_valid_q;

  assign xfer = (state_q == SEND) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_valid_q <= xfer && (index_q == LAST_IDX);
      if (accept)    sum_q <= '0;
      else if (xfer) sum_q <= sum_q + buf_q[index_q];
    end
  end

  assign bus.out_sum       = sum_q;
  assign bus.out_sum_valid = sum_valid_q;
`endif
endmodule

// File: tb/tb_matmult_result_serializer.sv
// Directed bench for matmult_result_serializer: reset, basic, backpressure, back-to-back, mid-send reset, wrap.
// Checksum checks are compiled in when SERIALIZER_CHECKSUM_EN is defined.
module tb_matmult_result_serializer;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  logic signed [63:0] exp_c [25];
  logic signed [63:0] nxt_c [25];

  matmult_result_serializer_if #(.DATA_W(64), .N_ELEM(25)) bus ();

  matmult_result_serializer #(.DATA_W(64), .N_ELEM(25)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // rdy_mode 0: always ready, 1: ready pattern 1,0,0,...
  // next_mode 0: drop in_valid after hold, 1: load nxt_c and keep in_valid high
  task automatic run_mat(input string tag, input int rdy_mode, input int next_mode);
    logic signed [63:0] cur [25];
    logic [63:0]        prev_data;
    logic [4:0]         prev_idx;
    logic               prev_stall;
    int                 acc_cnt, beat, hold, ridx;
`ifdef SERIALIZER_CHECKSUM_EN
    logic [63:0]        esum;
    esum = '0;
`endif
    acc_cnt = 0; beat = 0; hold = -1; ridx = 0;
    prev_stall = 1'b0; prev_data = '0; prev_idx = '0;
    for (int i = 0; i < 25; i++) begin
      cur[i] = exp_c[i];
      bus.in_c[i] = exp_c[i];
    end
    bus.in_valid = 1'b1;
    for (int c = 0; c < 300 && beat < 25; c++) begin
      cycle();
      bus.out_ready = (rdy_mode == 0) ? 1'b1 : ((ridx % 3) == 0);
      ridx++;
      if (bus.in_accept) begin
        acc_cnt++;
        hold = 2;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          if (next_mode == 1) begin
            for (int i = 0; i < 25; i++) bus.in_c[i] = nxt_c[i];
          end else begin
            bus.in_valid = 1'b0;
          end
        end
      end
      if (bus.out_valid) begin
        if (prev_stall) begin
          chk({tag, "_stall_data"}, bus.out_data, prev_data);
          chk({tag, "_stall_idx"}, {59'd0, bus.out_index}, {59'd0, prev_idx});
        end
        if (bus.out_ready) begin
          chk({tag, "_data"}, bus.out_data, cur[beat]);
          chk({tag, "_index"}, {59'd0, bus.out_index}, 64'(beat));
          chk({tag, "_last"}, {63'd0, bus.out_last}, {63'd0, beat == 24});
`ifdef SERIALIZER_CHECKSUM_EN
          esum = esum + cur[beat];
`endif
          beat++;
        end
        prev_stall = !bus.out_ready;
        prev_data  = bus.out_data;
        prev_idx   = bus.out_index;
      end
    end
    chk({tag, "_beats"}, 64'(beat), 64'd25);
    chk({tag, "_accepts"}, 64'(acc_cnt), 64'd1);
    cycle();
    chk({tag, "_idle_valid"}, {63'd0, bus.out_valid}, 64'd0);
    chk({tag, "_idle_accept"}, {63'd0, bus.in_accept}, 64'd0);
`ifdef SERIALIZER_CHECKSUM_EN
    chk({tag, "_sum_valid"}, {63'd0, bus.out_sum_valid}, 64'd1);
    chk({tag, "_sum"}, bus.out_sum, esum);
    cycle();
    chk({tag, "_sum_valid_pulse"}, {63'd0, bus.out_sum_valid}, 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 25; i++) bus.in_c[i] = 64'(i + 7);

    repeat (3) begin
      cycle();
      chk("rst_accept", {63'd0, bus.in_accept}, 64'd0);
      chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_data", bus.out_data, 64'd0);
      chk("rst_index", {59'd0, bus.out_index}, 64'd0);
      chk("rst_last", {63'd0, bus.out_last}, 64'd0);
`ifdef SERIALIZER_CHECKSUM_EN
      chk("rst_sum", bus.out_sum, 64'd0);
      chk("rst_sum_valid", {63'd0, bus.out_sum_valid}, 64'd0);
`endif
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    cycle();
    chk("post_rst_accept", {63'd0, bus.in_accept}, 64'd0);
    chk("post_rst_valid", {63'd0, bus.out_valid}, 64'd0);

    for (int i = 0; i < 25; i++) exp_c[i] = 64'(i + 1);
    run_mat("basic", 0, 0);

    for (int i = 0; i < 25; i++) exp_c[i] = -64'(i);
    run_mat("bp", 1, 0);

    for (int i = 0; i < 25; i++) begin
      exp_c[i] = 64'(i + 1);
      nxt_c[i] = 64'(100 + i);
    end
    run_mat("b2b_a", 0, 1);
    for (int i = 0; i < 25; i++) exp_c[i] = nxt_c[i];
    run_mat("b2b_b", 0, 0);

    // Abort a matrix part-way through and confirm the next one starts clean
    for (int i = 0; i < 25; i++) bus.in_c[i] = 64'(i + 50);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (bus.in_accept) begin
        bus.in_valid = 1'b0;
        break;
      end
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid && bus.out_index == 5'd10) break;
      cycle();
    end
    chk("mid_reached_idx", {59'd0, bus.out_index}, 64'd10);
    chk("mid_reached_data", bus.out_data, 64'd60);
    rst = 1'b1;
    cycle();
    chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_rst_accept", {63'd0, bus.in_accept}, 64'd0);
    chk("mid_rst_index", {59'd0, bus.out_index}, 64'd0);
    rst = 1'b0;
    cycle();
    chk("mid_post_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_post_accept", {63'd0, bus.in_accept}, 64'd0);
    for (int i = 0; i < 25; i++) exp_c[i] = 64'(i + 1);
    run_mat("after_rst", 0, 0);

    for (int i = 0; i < 25; i++) exp_c[i] = 64'h7FFF_FFFF_FFFF_FFFF;
    run_mat("wrap", 0, 0);
`ifdef SERIALIZER_CHECKSUM_EN
    chk("wrap_sum_hold", bus.out_sum, 64'h7FFF_FFFF_FFFF_FFE7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
